// File: rtl/cbus_sram_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cbus_sram_bridge: CBus burst requests onto a single-port SRAM plus a timer.
// Rev 1.0
// ----------------------------------------------------------------------------
module cbus_sram_bridge #(
  parameter int unsigned DATA_W     = 64,
  parameter logic [63:0] MEM_BASE   = 64'h8000_0000,
  parameter int unsigned MEM_AW     = 28,
  parameter int unsigned LATENCY    = 0,
  parameter logic [63:0] TIMER_ADDR = 64'h3800_bff8,
  parameter int unsigned TICK_DIV   = 10000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_is_write,
  input  logic [63:0]         req_addr,
  input  logic [2:0]          req_size,
  input  logic [7:0]          req_len,
  input  logic [1:0]          req_burst,
  input  logic [DATA_W/8-1:0] req_strobe,
  input  logic [DATA_W-1:0]   req_data,
  output logic                resp_ready,
  output logic                resp_last,
  output logic                resp_err,
  output logic [DATA_W-1:0]   resp_data,
  output logic [63:0]         sram_idx,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic [DATA_W-1:0]   sram_wdata,
  output logic [DATA_W-1:0]   sram_wmask,
  output logic                sram_wen,
  output logic                sram_en
);

  localparam int unsigned c_SHIFT     = $clog2(DATA_W / 8);
  localparam logic [9:0]  c_WAIT_LAST = (LATENCY > 0) ? 10'(LATENCY - 1) : 10'd0;
  localparam logic [31:0] c_PRE_LAST  = 32'(TICK_DIV - 1);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_WAIT = 2'd1;
  localparam logic [1:0] c_S_BEAT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [7:0]  k_q, k_d;
  logic [9:0]  wait_q, wait_d;
  logic [31:0] pre_q, pre_d;
  logic [63:0] timer_q, timer_d;

  logic        w_in_beat;
  logic        w_len_ok;
  logic        w_err;
  logic [63:0] w_step;
  logic [63:0] w_wrap_mask;
  logic [63:0] w_beat_addr;
  logic [63:0] w_off;
  logic        w_in_win;
  logic        w_is_timer;
  logic        w_timer_wr;
  logic        w_tick;
  logic [63:0] w_timer_wr_val;

  // Request fields are not latched: the requester holds them for the whole burst.
  assign w_in_beat = (state_q == c_S_BEAT) && req_valid;

  always_comb begin
    case (req_len)
      8'd1, 8'd3, 8'd7, 8'd15: w_len_ok = 1'b1;
      default:                 w_len_ok = 1'b0;
    endcase
  end

  assign w_err = (req_burst == 2'd3) ||
                 ((req_burst != 2'd0) && (req_size != 3'(c_SHIFT))) ||
                 ((req_burst == 2'd2) && !w_len_ok);

  assign w_step      = 64'(k_q) << c_SHIFT;
  assign w_wrap_mask = ((64'(req_len) + 64'd1) << c_SHIFT) - 64'd1;

  always_comb begin
    case (req_burst)
      2'd1:    w_beat_addr = req_addr + w_step;
      2'd2:    w_beat_addr = (req_addr & ~w_wrap_mask) | ((req_addr + w_step) & w_wrap_mask);
      default: w_beat_addr = req_addr;
    endcase
  end

  // Addresses below MEM_BASE underflow to huge offsets and fall outside the window.
  assign w_off      = w_beat_addr - MEM_BASE;
  assign w_in_win   = (w_off >> MEM_AW) == 64'd0;
  assign w_is_timer = (w_beat_addr == TIMER_ADDR);

  assign resp_ready = w_in_beat;
  assign resp_last  = w_in_beat && (k_q == req_len);
  assign resp_err   = w_in_beat && w_err;
  assign sram_en    = w_in_beat;
  assign sram_wen   = w_in_beat && req_is_write && !w_err && w_in_win && !reset;
  assign sram_idx   = w_off >> c_SHIFT;
  assign sram_wdata = req_data;

  for (genvar i = 0; i < DATA_W / 8; i++) begin : g_wmask
    assign sram_wmask[i*8 +: 8] = {8{req_strobe[i]}};
  end

  always_comb begin
    resp_data = '0;
    if (w_in_beat && !w_err) begin
      if (w_in_win)        resp_data = sram_rdata;
      else if (w_is_timer) resp_data = DATA_W'(timer_q);
    end
  end

  assign w_timer_wr = w_in_beat && req_is_write && !w_err && w_is_timer && !reset;
  assign w_tick     = (pre_q == c_PRE_LAST);

  always_comb begin
    w_timer_wr_val = timer_q;
    for (int i = 0; i < 8; i++) begin
      if (req_strobe[i]) w_timer_wr_val[i*8 +: 8] = req_data[i*8 +: 8];
    end
  end

  // A software write overrides a tick landing in the same cycle.
  always_comb begin
    pre_d   = w_tick ? 32'd0 : pre_q + 32'd1;
    timer_d = timer_q;
    if (w_timer_wr)  timer_d = w_timer_wr_val;
    else if (w_tick) timer_d = timer_q + 64'd1;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wait_d  = wait_q;
    case (state_q)
      c_S_IDLE: begin
        if (req_valid) begin
          if (LATENCY > 0) begin
            state_d = c_S_WAIT;
            wait_d  = 10'd0;
          end else begin
            state_d = c_S_BEAT;
            k_d     = 8'd0;
          end
        end
      end
      c_S_WAIT: begin
        if (!req_valid) begin
          state_d = c_S_IDLE;
        end else if (wait_q == c_WAIT_LAST) begin
          state_d = c_S_BEAT;
          k_d     = 8'd0;
        end else begin
          wait_d = wait_q + 10'd1;
        end
      end
      c_S_BEAT: begin
        if (!req_valid || (k_q == req_len)) state_d = c_S_IDLE;
        else                                k_d     = k_q + 8'd1;
      end
      default: state_d = c_S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_S_IDLE;
      k_q     <= 8'd0;
      wait_q  <= 10'd0;
      pre_q   <= 32'd0;
      timer_q <= 64'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wait_q  <= wait_d;
      pre_q   <= pre_d;
      timer_q <= timer_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cbus_sram_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cbus_sram_bridge: directed and randomized checks of cbus_sram_bridge.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cbus_sram_bridge;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [63:0] TADDR = 64'h3800_bff8;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid0, valid5, is_write;
  logic [63:0] addr, data;
  logic [2:0]  size;
  logic [7:0]  len, strobe;
  logic [1:0]  burst;

  logic        ready0, last0, err0, wen0, en0;
  logic [63:0] rdata0, idx0, srd0, wdata0, wmask0;
  logic        ready5, last5, err5, wen5, en5;
  logic [63:0] rdata5, idx5, srd5, wdata5, wmask5;

  logic [63:0] mem  [64] = '{default: 64'h0};
  logic [63:0] refm [64] = '{default: 64'h0};
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic        sel5;
  logic        v_ready, v_last, v_err, v_wen;
  logic [63:0] v_data, v_idx, v_wdata, v_wmask;

  always #5 clk = ~clk;

  cbus_sram_bridge #(.LATENCY(0), .TICK_DIV(4)) dut0 (
    .clk(clk), .reset(reset), .req_valid(valid0), .req_is_write(is_write),
    .req_addr(addr), .req_size(size), .req_len(len), .req_burst(burst),
    .req_strobe(strobe), .req_data(data), .resp_ready(ready0), .resp_last(last0),
    .resp_err(err0), .resp_data(rdata0), .sram_idx(idx0), .sram_rdata(srd0),
    .sram_wdata(wdata0), .sram_wmask(wmask0), .sram_wen(wen0), .sram_en(en0));

  cbus_sram_bridge #(.LATENCY(5), .TICK_DIV(4)) dut5 (
    .clk(clk), .reset(reset), .req_valid(valid5), .req_is_write(is_write),
    .req_addr(addr), .req_size(size), .req_len(len), .req_burst(burst),
    .req_strobe(strobe), .req_data(data), .resp_ready(ready5), .resp_last(last5),
    .resp_err(err5), .resp_data(rdata5), .sram_idx(idx5), .sram_rdata(srd5),
    .sram_wdata(wdata5), .sram_wmask(wmask5), .sram_wen(wen5), .sram_en(en5));

  // Small SRAM aliased on the low index bits; serves both instances.
  assign srd0 = mem[idx0[5:0]];
  assign srd5 = mem[idx5[5:0]];
  always @(posedge clk) begin
    if (wen0) mem[idx0[5:0]] <= (mem[idx0[5:0]] & ~wmask0) | (wdata0 & wmask0);
    if (wen5) mem[idx5[5:0]] <= (mem[idx5[5:0]] & ~wmask5) | (wdata5 & wmask5);
  end

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  assign v_ready = sel5 ? ready5 : ready0;
  assign v_last  = sel5 ? last5  : last0;
  assign v_err   = sel5 ? err5   : err0;
  assign v_wen   = sel5 ? wen5   : wen0;
  assign v_data  = sel5 ? rdata5 : rdata0;
  assign v_idx   = sel5 ? idx5   : idx0;
  assign v_wdata = sel5 ? wdata5 : wdata0;
  assign v_wmask = sel5 ? wmask5 : wmask0;

  function automatic logic [63:0] beat_addr(input logic [63:0] a, input logic [7:0] l,
                                            input logic [1:0] b, input int k);
    logic [63:0] win, lo;
    case (b)
      2'd1: return a + 64'(k) * 64'd8;
      2'd2: begin
        win = (64'(l) + 64'd1) * 64'd8;
        lo  = a - (a % win);
        return lo + ((a - lo + 64'(k) * 64'd8) % win);
      end
      default: return a;
    endcase
  endfunction

  function automatic bit is_err(input logic [2:0] s, input logic [7:0] l, input logic [1:0] b);
    return (b == 2'd3) || (b != 2'd0 && s != 3'd3) ||
           (b == 2'd2 && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15));
  endfunction

  function automatic bit in_win(input logic [63:0] x);
    return (x >= BASE) && (x < BASE + (64'd1 << 28));
  endfunction

  function automatic logic [63:0] expand(input logic [7:0] st);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{st[i]}};
    return m;
  endfunction

  task automatic set_req(input bit w, input logic [63:0] a, input logic [2:0] s,
                         input logic [7:0] l, input logic [1:0] b,
                         input logic [7:0] st, input logic [63:0] d);
    is_write = w; addr = a; size = s; len = l; burst = b; strobe = st; data = d;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if ({ready0, last0, err0, wen0, en0, ready5, last5, err5, wen5, en5} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0",
               {ready0, last0, err0, wen0, en0, ready5, last5, err5, wen5, en5});
    end
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ready0, wen0, ready5, wen5, rdata0} !== 68'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b/%h expected 0", {ready0, wen0, ready5, wen5}, rdata0);
    end
  endtask

  task automatic test_incr_read;
    logic [63:0] ea;
    @(posedge clk); #1;
    set_req(1'b0, BASE, 3'd3, 8'd3, 2'd1, 8'h00, 64'd0);
    valid0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      ea = beat_addr(BASE, 8'd3, 2'd1, k);
      n_checks++;
      if ({ready0, last0, err0, idx0} !== {1'b1, (k == 3), 1'b0, 64'(k)}) begin
        n_fail++;
        $display("FAIL incr_read_beat%0d: got rdy/last/err/idx %b%b%b %0d expected 1%b0 %0d",
                 k, ready0, last0, err0, idx0, (k == 3), k);
      end
      n_checks++;
      if (rdata0 !== refm[(ea - BASE) >> 3]) begin
        n_fail++;
        $display("FAIL incr_read_data%0d: got %h expected %h", k, rdata0, refm[(ea - BASE) >> 3]);
      end
    end
    @(posedge clk); #1; valid0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready0 !== 1'b0) begin
      n_fail++;
      $display("FAIL incr_read_end: got ready %b expected 0", ready0);
    end
  endtask

  task automatic test_fixed_write_latency;
    @(posedge clk); #1;
    set_req(1'b1, BASE + 64'h10, 3'd3, 8'd0, 2'd0, 8'h0F, 64'h1122334455667788);
    valid5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if ({ready5, wen5} !== 2'b00) begin
        n_fail++;
        $display("FAIL latency_wait%0d: got ready/wen %b%b expected 00", i, ready5, wen5);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({ready5, last5, wen5, idx5} !== {3'b111, 64'd2}) begin
      n_fail++;
      $display("FAIL fixed_write_beat: got rdy/last/wen %b%b%b idx %0d expected 111 idx 2",
               ready5, last5, wen5, idx5);
    end
    n_checks++;
    if ({wmask5, wdata5} !== {64'h0000_0000_FFFF_FFFF, 64'h1122334455667788}) begin
      n_fail++;
      $display("FAIL fixed_write_mask: got %h/%h expected 00000000ffffffff/1122334455667788",
               wmask5, wdata5);
    end
    refm[2] = (refm[2] & ~64'h0000_0000_FFFF_FFFF) | 64'h0000_0000_5566_7788;
    @(posedge clk); #1; valid5 = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ready5, wen5} !== 2'b00) begin
      n_fail++;
      $display("FAIL fixed_write_end: got ready/wen %b%b expected 00", ready5, wen5);
    end
  endtask

  task automatic test_wrap;
    logic [63:0] ea;
    @(posedge clk); #1;
    set_req(1'b0, BASE + 64'h28, 3'd3, 8'd3, 2'd2, 8'h00, 64'd0);
    valid0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      ea = beat_addr(BASE + 64'h28, 8'd3, 2'd2, k);
      n_checks++;
      if ({ready0, err0, idx0} !== {2'b10, (ea - BASE) >> 3}) begin
        n_fail++;
        $display("FAIL wrap_beat%0d: got rdy/err %b%b idx %0d expected 10 idx %0d",
                 k, ready0, err0, idx0, (ea - BASE) >> 3);
      end
    end
    @(posedge clk); #1; valid0 = 1'b0;
  endtask

  task automatic test_error;
    @(posedge clk); #1;
    set_req(1'b1, BASE + 64'h40, 3'd2, 8'd3, 2'd1, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D);
    valid0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if ({ready0, err0, wen0, last0, rdata0} !== {3'b110, (k == 3), 64'd0}) begin
        n_fail++;
        $display("FAIL error_beat%0d: got rdy/err/wen/last %b%b%b%b data %h expected 110%b data 0",
                 k, ready0, err0, wen0, last0, rdata0, (k == 3));
      end
    end
    @(posedge clk); #1; valid0 = 1'b0;
  endtask

  task automatic test_abort;
    @(posedge clk); #1;
    set_req(1'b1, BASE + 64'h80, 3'd3, 8'd7, 2'd1, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0);
    valid5 = 1'b1;
    repeat (2) @(posedge clk);
    #1; valid5 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if ({ready5, wen5} !== 2'b00) begin
        n_fail++;
        $display("FAIL abort_wait%0d: got ready/wen %b%b expected 00", i, ready5, wen5);
      end
    end
    @(posedge clk); #1;
    valid0 = 1'b1;
    repeat (3) @(posedge clk);
    #1; valid0 = 1'b0;
    refm[16] = 64'hA5A5_5A5A_0F0F_F0F0;
    refm[17] = 64'hA5A5_5A5A_0F0F_F0F0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ready0, wen0} !== 2'b00) begin
        n_fail++;
        $display("FAIL abort_beat%0d: got ready/wen %b%b expected 00", i, ready0, wen0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random;
    logic [63:0] a, d, ea, ei, ed, em;
    logic [7:0]  l, st;
    logic [2:0]  s;
    logic [1:0]  b;
    bit          w, e, ew;
    int          lat, r;
    for (int n = 0; n < 60; n++) begin
      sel5 = (n % 2 == 1);
      lat  = sel5 ? 5 : 0;
      b = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      s = ($urandom_range(0, 5) == 0) ? 3'd2 : 3'd3;
      if (b == 2'd2)
        l = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 15)) : 8'((2 << $urandom_range(0, 3)) - 1);
      else
        l = 8'($urandom_range(0, 7));
      r = $urandom_range(0, 7);
      if (r == 0)      a = 64'h7FFF_FFF0;
      else if (r == 1) a = BASE + (64'd1 << 28) - 64'd16;
      else             a = BASE + 64'($urandom_range(0, 63)) * 64'd8;
      w  = 1'($urandom_range(0, 1));
      st = 8'($urandom);
      d  = {$urandom, $urandom};
      e  = is_err(s, l, b);
      @(posedge clk); #1;
      set_req(w, a, s, l, b, st, d);
      if (sel5) valid5 = 1'b1; else valid0 = 1'b1;
      for (int i = 0; i < lat; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({v_ready, v_wen} !== 2'b00) begin
          n_fail++;
          $display("FAIL rand%0d_wait%0d: got ready/wen %b%b expected 00", n, i, v_ready, v_wen);
        end
      end
      for (int k = 0; k <= int'(l); k++) begin
        @(posedge clk); #1;
        @(negedge clk);
        ea = beat_addr(a, l, b, k);
        ew = w && !e && in_win(ea);
        ei = (ea - BASE) >> 3;
        ed = (!e && in_win(ea)) ? refm[ei[5:0]] : 64'd0;
        n_checks++;
        if ({v_ready, v_last, v_err, v_wen} !== {1'b1, (k == int'(l)), e, ew}) begin
          n_fail++;
          $display("FAIL rand%0d_ctl%0d: got rdy/last/err/wen %b%b%b%b expected 1%b%b%b",
                   n, k, v_ready, v_last, v_err, v_wen, (k == int'(l)), e, ew);
        end
        n_checks++;
        if (v_data !== ed) begin
          n_fail++;
          $display("FAIL rand%0d_data%0d: got %h expected %h", n, k, v_data, ed);
        end
        if (!e) begin
          n_checks++;
          if (v_idx !== ei) begin
            n_fail++;
            $display("FAIL rand%0d_idx%0d: got %h expected %h", n, k, v_idx, ei);
          end
        end
        if (ew) begin
          em = expand(st);
          n_checks++;
          if ({v_wmask, v_wdata} !== {em, d}) begin
            n_fail++;
            $display("FAIL rand%0d_wr%0d: got %h/%h expected %h/%h", n, k, v_wmask, v_wdata, em, d);
          end
          refm[ei[5:0]] = (refm[ei[5:0]] & ~em) | (d & em);
        end
      end
      @(posedge clk); #1;
      valid0 = 1'b0; valid5 = 1'b0;
      @(negedge clk);
      n_checks++;
      if (v_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_end: got ready %b expected 0", n, v_ready);
      end
    end
    sel5 = 1'b0;
  endtask

  task automatic test_timer;
    logic [63:0] oldv, expv;
    int cw, c0;
    @(posedge clk); #1; reset = 1'b1; valid0 = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    while (cyc != 11) begin @(posedge clk); #1; end
    set_req(1'b0, TADDR, 3'd3, 8'd0, 2'd0, 8'h00, 64'd0);
    valid0 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({ready0, rdata0} !== {1'b1, 64'd3}) begin
      n_fail++;
      $display("FAIL timer_count: got ready %b data %h expected 1 data 3", ready0, rdata0);
    end
    @(posedge clk); #1; valid0 = 1'b0;
    while ((cyc + 2) % 4 != 0) begin @(posedge clk); #1; end
    set_req(1'b1, TADDR, 3'd3, 8'd0, 2'd0, 8'hFF, 64'h100);
    valid0 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({ready0, wen0} !== 2'b10) begin
      n_fail++;
      $display("FAIL timer_write_beat: got ready/wen %b%b expected 10", ready0, wen0);
    end
    @(posedge clk); #1;
    cw = cyc;
    set_req(1'b0, TADDR, 3'd3, 8'd0, 2'd0, 8'h00, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (rdata0 !== 64'h100) begin
      n_fail++;
      $display("FAIL timer_write_wins: got %h expected 100", rdata0);
    end
    @(posedge clk); #1; valid0 = 1'b0;
    repeat ($urandom_range(1, 6)) begin @(posedge clk); #1; end
    set_req(1'b1, TADDR, 3'd3, 8'd0, 2'd0, 8'h01, 64'hFFFF_FFFF_FFFF_FFAB);
    valid0 = 1'b1;
    @(posedge clk); #1;
    c0   = cyc;
    oldv = 64'h100 + 64'(c0 / 4 - cw / 4);
    @(posedge clk); #1;
    cw = cyc;
    set_req(1'b0, TADDR, 3'd3, 8'd0, 2'd0, 8'h00, 64'd0);
    @(posedge clk); #1;
    expv = {oldv[63:8], 8'hAB} + 64'(cyc / 4 - cw / 4);
    @(negedge clk);
    n_checks++;
    if (rdata0 !== expv) begin
      n_fail++;
      $display("FAIL timer_strobe_merge: got %h expected %h", rdata0, expv);
    end
    @(posedge clk); #1; valid0 = 1'b0;
  endtask

  task automatic test_reset_mid_burst;
    @(posedge clk); #1;
    set_req(1'b1, BASE + 64'h100, 3'd3, 8'd7, 2'd1, 8'hFF, 64'h0123_4567_89AB_CDEF);
    valid0 = 1'b1;
    repeat (3) @(posedge clk);
    #1; reset = 1'b1;
    refm[32] = 64'h0123_4567_89AB_CDEF;
    refm[33] = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    n_checks++;
    if (wen0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cycle_wen: got %b expected 0", wen0);
    end
    @(posedge clk); #1;
    reset = 1'b0; valid0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ready0, last0, err0, wen0, rdata0} !== 68'd0) begin
        n_fail++;
        $display("FAIL reset_mid_idle%0d: got %b%b%b%b data %h expected 0000 data 0",
                 i, ready0, last0, err0, wen0, rdata0);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (mem[34] !== refm[34] || mem[32] !== refm[32]) begin
      n_fail++;
      $display("FAIL reset_mid_mem: got %h/%h expected %h/%h", mem[32], mem[34], refm[32], refm[34]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; valid0 = 1'b0; valid5 = 1'b0; sel5 = 1'b0;
    set_req(1'b0, 64'd0, 3'd3, 8'd0, 2'd0, 8'h00, 64'd0);
    test_reset;
    test_incr_read;
    test_fixed_write_latency;
    test_wrap;
    test_error;
    test_abort;
    test_random;
    test_timer;
    test_reset_mid_burst;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
